// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch stage: default widths, reset PC, PC step and empty-head value.
package fetch_queue_pkg;

   localparam int unsigned XLEN_DEFAULT     = 32;
   localparam int unsigned RESET_PC_DEFAULT = 0;
   localparam int unsigned PC_STEP          = 4;
   localparam int unsigned EMPTY_INSTR      = 0;
   localparam int unsigned PERF_W           = 32;

   // Saturating increment for the performance counters.
   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (v == '1) ? v : v + PERF_W'(1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush; DEPTH must be a power of two (>= 2).
module fetch_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full & ~i_flush;
   assign w_pop   = i_pop & ~o_empty & ~i_flush;
   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC, stall-tolerant memory requests, redirect flush and a head FIFO.
// Optional performance counters enabled by defining FETCH_QUEUE_PERF_EN.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned    XLEN     = XLEN_DEFAULT,
   parameter int unsigned    DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_en,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_addr,
   input  logic            deq,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_step,
   output logic            redirect_stall
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_fetched,
   output logic [PERF_W-1:0] perf_imem_stall,
   output logic [PERF_W-1:0] perf_flushes
`endif
);

   localparam int unsigned FW = 3 * XLEN;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_step;
   logic            w_req;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [CW-1:0]   w_count;
   logic [FW-1:0]   w_head;
   logic            w_unused_bits;

   assign w_pc_step = r_pc + XLEN'(PC_STEP);

   // w_req is the request intent before redirect suppression.
   assign w_req          = ~w_full;
   assign imem_en        = w_req & ~redirect_valid;
   assign imem_addr      = r_pc;
   assign w_push         = imem_en & imem_ready;
   assign w_pop          = deq & ~w_empty & ~redirect_valid;
   assign redirect_stall = redirect_valid & w_req & ~imem_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 r_pc <= RESET_PC;
      else if (redirect_valid) r_pc <= {redirect_addr[XLEN-1:2], 2'b00};
      else if (w_push)         r_pc <= w_pc_step;
   end

   fetch_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_wdata ({imem_rdata, r_pc, w_pc_step}),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign instr_valid   = ~w_empty;
   assign instr         = w_empty ? XLEN'(EMPTY_INSTR) : w_head[3*XLEN-1:2*XLEN];
   assign instr_pc      = w_empty ? XLEN'(EMPTY_INSTR) : w_head[2*XLEN-1:XLEN];
   assign instr_pc_step = w_empty ? XLEN'(EMPTY_INSTR) : w_head[XLEN-1:0];

   // Redirect targets are word-aligned, so the low address bits are dropped.
   assign w_unused_bits = ^{redirect_addr[1:0], w_count};

`ifdef FETCH_QUEUE_PERF_EN
   logic [PERF_W-1:0] r_perf_fetched;
   logic [PERF_W-1:0] r_perf_imem_stall;
   logic [PERF_W-1:0] r_perf_flushes;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_fetched    <= '0;
         r_perf_imem_stall <= '0;
         r_perf_flushes    <= '0;
      end else begin
         if (w_push)                r_perf_fetched    <= sat_inc(r_perf_fetched);
         if (imem_en & ~imem_ready) r_perf_imem_stall <= sat_inc(r_perf_imem_stall);
         if (redirect_valid)        r_perf_flushes    <= sat_inc(r_perf_flushes);
      end
   end

   assign perf_fetched    = r_perf_fetched;
   assign perf_imem_stall = r_perf_imem_stall;
   assign perf_flushes    = r_perf_flushes;
`endif

endmodule
